// File: rtl/freq_range_sequencer.sv
// Measurement sequencer for the frequency meter: generates gate/clear/latch
// strobes and auto-selects the /1 or /100 input range from the previous gate.
module freq_range_sequencer #(
    parameter int unsigned GATE_CYCLES   = 100_000_000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DOWN_THRESH   = 90
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       auto_en,
    input  logic       manual_high,
    input  logic [3:0] s3,
    input  logic [3:0] s2,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    input  logic       ovf,
    output logic       enable,
    output logic       clr,
    output logic       save,
    output logic       highfreq,
    output logic       overrange,
    output logic       busy_rerange
);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_EVAL,
        ST_SAVE,
        ST_RERANGE
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] gate_cnt_q, gate_cnt_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic        ovf_meta_q, ovf_meta_d;
    logic        ovf_sync_q, ovf_sync_d;
    logic        ovf_eval_q, ovf_eval_d;
    logic        auto_q, auto_d;
    logic        enable_q, enable_d;
    logic        clr_q, clr_d;
    logic        save_q, save_d;
    logic        highfreq_q, highfreq_d;
    logic        overrange_q, overrange_d;
    logic        busy_q, busy_d;

    logic [13:0] count_n;
    logic        digits_ok;
    logic        below_thresh;

    // An invalid BCD digit never counts as below the down-switch threshold.
    always_comb begin
        digits_ok    = (s3 <= 4'd9) && (s2 <= 4'd9) && (s1 <= 4'd9) && (s0 <= 4'd9);
        count_n      = 14'(s3) * 14'd1000 + 14'(s2) * 14'd100 + 14'(s1) * 14'd10 + 14'(s0);
        below_thresh = digits_ok && (32'(count_n) < DOWN_THRESH);
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        settle_cnt_d = settle_cnt_q;
        ovf_meta_d   = ovf;
        ovf_sync_d   = ovf_meta_q;
        ovf_eval_d   = ovf_eval_q;
        auto_d       = auto_q;
        enable_d     = 1'b0;
        clr_d        = 1'b0;
        save_d       = 1'b0;
        highfreq_d   = highfreq_q;
        overrange_d  = overrange_q;
        busy_d       = busy_q;

        case (state_q)
            ST_CLEAR: begin
                clr_d      = 1'b1;
                auto_d     = auto_en;
                if (!auto_en) highfreq_d = manual_high;
                gate_cnt_d = 27'(GATE_CYCLES - 1);
                state_d    = ST_GATE;
            end
            ST_GATE: begin
                enable_d = 1'b1;
                if (gate_cnt_q == '0) begin
                    settle_cnt_d = 8'(SETTLE_CYCLES - 1);
                    state_d      = ST_SETTLE;
                end else begin
                    gate_cnt_d = gate_cnt_q - 27'd1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) state_d = ST_EVAL;
                else                    settle_cnt_d = settle_cnt_q - 8'd1;
            end
            ST_EVAL: begin
                ovf_eval_d = ovf_sync_q;
                if (auto_q && !highfreq_q && ovf_sync_q)
                    state_d = ST_RERANGE;
                else if (auto_q && highfreq_q && !ovf_sync_q && below_thresh)
                    state_d = ST_RERANGE;
                else
                    state_d = ST_SAVE;
            end
            ST_SAVE: begin
                save_d      = 1'b1;
                overrange_d = ovf_eval_q;
                busy_d      = 1'b0;
                state_d     = ST_CLEAR;
            end
            ST_RERANGE: begin
                highfreq_d = !highfreq_q;
                busy_d     = 1'b1;
                state_d    = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            gate_cnt_q   <= '0;
            settle_cnt_q <= '0;
            ovf_meta_q   <= 1'b0;
            ovf_sync_q   <= 1'b0;
            ovf_eval_q   <= 1'b0;
            auto_q       <= 1'b0;
            enable_q     <= 1'b0;
            clr_q        <= 1'b0;
            save_q       <= 1'b0;
            highfreq_q   <= 1'b0;
            overrange_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            ovf_meta_q   <= ovf_meta_d;
            ovf_sync_q   <= ovf_sync_d;
            ovf_eval_q   <= ovf_eval_d;
            auto_q       <= auto_d;
            enable_q     <= enable_d;
            clr_q        <= clr_d;
            save_q       <= save_d;
            highfreq_q   <= highfreq_d;
            overrange_q  <= overrange_d;
            busy_q       <= busy_d;
        end
    end

    assign enable       = enable_q;
    assign clr          = clr_q;
    assign save         = save_q;
    assign highfreq     = highfreq_q;
    assign overrange    = overrange_q;
    assign busy_rerange = busy_q;

endmodule

// File: tb/tb_freq_range_sequencer.sv
// Scoreboard bench for freq_range_sequencer: stimulus pushes the expected
// outcome of each measurement period; a monitor pops it on save/rerange.
module tb_freq_range_sequencer;

    localparam int GATE   = 20;
    localparam int SETTLE = 4;
    localparam int PERIOD = 1 + GATE + SETTLE + 2;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       auto_en = 1'b1;
    logic       manual_high = 1'b0;
    logic       ovf = 1'b0;
    logic [3:0] s3 = '0, s2 = '0, s1 = '0, s0 = '0;
    logic       enable, clr, save, highfreq, overrange, busy_rerange;

    typedef struct {
        bit rr;
        bit hf;
        bit ovr;
        bit busy;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;

    freq_range_sequencer #(
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .DOWN_THRESH   (90)
    ) dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .auto_en      (auto_en),
        .manual_high  (manual_high),
        .s3           (s3),
        .s2           (s2),
        .s1           (s1),
        .s0           (s0),
        .ovf          (ovf),
        .enable       (enable),
        .clr          (clr),
        .save         (save),
        .highfreq     (highfreq),
        .overrange    (overrange),
        .busy_rerange (busy_rerange)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: period/gate timing per CLEAR, and scoreboard pop on each outcome.
    int   last_clr = -1;
    int   en_cnt = 0;
    int   first_en = -1;
    bit   hf_prev = 1'b0;
    exp_t mon_e;

    always @(negedge sysclk) begin
        if (!reset_n) begin
            last_clr = -1;
            en_cnt   = 0;
            first_en = -1;
        end else begin
            if (enable && clr) chk("enable_clr_overlap", 1, 0);
            if (save && enable) chk("save_enable_overlap", 1, 0);
            if (clr) begin
                if (last_clr >= 0) chk("period", cyc - last_clr, PERIOD);
                last_clr = cyc;
                en_cnt   = 0;
                first_en = -1;
            end
            if (enable) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
            end
            if (save || (highfreq != hf_prev && !clr)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_is_rerange", int'(!save), int'(mon_e.rr));
                    chk("event_latency", cyc - last_clr, PERIOD - 1);
                    chk("gate_length", en_cnt, GATE);
                    chk("gate_start", first_en - last_clr, 1);
                    chk("highfreq", int'(highfreq), int'(mon_e.hf));
                    chk("overrange", int'(overrange), int'(mon_e.ovr));
                    chk("busy_rerange", int'(busy_rerange), int'(mon_e.busy));
                end
            end
        end
        hf_prev = highfreq;
    end

    task automatic wait_clr(output int n);
        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!clr && n < 200);
        if (!clr) chk("clr_timeout", 0, 1);
    endtask

    // Called right after a CLEAR: queue the expected outcome and drive the counter model.
    task automatic start_period(input bit ov, input logic [15:0] digits,
                                input bit rr, input bit hf, input bit ovr, input bit busy);
        exp_t e;
        chk("missing_event", exp_q.size(), 0);
        e.rr = rr; e.hf = hf; e.ovr = ovr; e.busy = busy;
        exp_q.push_back(e);
        {s3, s2, s1, s0} = digits;
        ovf = 1'b0;
        repeat (3) @(negedge sysclk);
        ovf = ov;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_enable", int'(enable), 0);
        chk("rst_clr", int'(clr), 0);
        chk("rst_save", int'(save), 0);
        chk("rst_highfreq", int'(highfreq), 0);
        chk("rst_overrange", int'(overrange), 0);
        chk("rst_busy", int'(busy_rerange), 0);
        reset_n = 1'b1;

        wait_clr(n); chk("first_clr_cycle", n, 1);
        start_period(1'b0, 16'h0000, 0, 0, 0, 0);
        wait_clr(n); start_period(1'b1, 16'h0000, 1, 1, 0, 1);
        wait_clr(n); start_period(1'b0, 16'h0150, 0, 1, 0, 0);
        wait_clr(n); start_period(1'b0, 16'h0089, 1, 0, 0, 1);
        wait_clr(n); start_period(1'b1, 16'h0000, 1, 1, 0, 1);
        wait_clr(n); start_period(1'b0, 16'h0090, 0, 1, 0, 0);
        wait_clr(n); start_period(1'b0, 16'h000A, 0, 1, 0, 0);
        auto_en = 1'b0;
        manual_high = 1'b0;

        wait_clr(n); chk("manual_hf_at_clear", int'(highfreq), 0);
        start_period(1'b1, 16'h0000, 0, 0, 1, 0);
        wait_clr(n); start_period(1'b0, 16'h0000, 0, 0, 0, 0);
        manual_high = 1'b1;
        repeat (5) @(negedge sysclk);
        chk("hf_hold_midgate", int'(highfreq), 0);
        wait_clr(n); chk("manual_hf_next_clear", int'(highfreq), 1);
        start_period(1'b1, 16'h0005, 0, 1, 1, 0);

        wait_clr(n); chk("missing_event", exp_q.size(), 0);
        auto_en = 1'b1;
        ovf = 1'b0;
        repeat (10) @(negedge sysclk);
        chk("gate_active_before_reset", int'(enable), 1);
        reset_n = 1'b0;
        @(negedge sysclk);
        chk("midgate_rst_enable", int'(enable), 0);
        chk("midgate_rst_save", int'(save), 0);
        chk("midgate_rst_highfreq", int'(highfreq), 0);
        chk("midgate_rst_overrange", int'(overrange), 0);
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        wait_clr(n); chk("restart_clr_cycle", n, 1);
        start_period(1'b0, 16'h0000, 0, 0, 0, 0);
        wait_clr(n); chk("missing_event", exp_q.size(), 0);

        @(negedge sysclk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
